// File: rtl/pong_ctrl_pkg.sv
// Shared types and default timing constants for the match sequencer.
package pong_ctrl_pkg;

  typedef enum logic [2:0] {
    ATTRACT    = 3'd0,
    CLEAR      = 3'd1,
    SERVE_WAIT = 3'd2,
    PLAY       = 3'd3,
    POINT      = 3'd4,
    OVER       = 3'd5
  } match_state_t;

  localparam int SRST_CYCLES_DEF  = 4;
  localparam int SERVE_FRAMES_DEF = 60;
  localparam int OVER_FRAMES_DEF  = 180;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/match_sequencer_if.sv
// Control/status bundle between the match sequencer and the coin, score and ball blocks.
interface match_sequencer_if;
  logic       FRAME_TICK;
  logic       COIN;
  logic       MISS_N;
  logic       L;
  logic       STOP_G;
  logic       SRST;
  logic       SRST_N;
  logic       ATTRACT_N;
  logic       SERVE_HOLD;
  logic       MISS_PULSE;
  logic       MISS_LEFT;
  logic [2:0] STATE;

  modport master (
    output FRAME_TICK, COIN, MISS_N, L, STOP_G,
    input  SRST, SRST_N, ATTRACT_N, SERVE_HOLD, MISS_PULSE, MISS_LEFT, STATE
  );

  modport slave (
    input  FRAME_TICK, COIN, MISS_N, L, STOP_G,
    output SRST, SRST_N, ATTRACT_N, SERVE_HOLD, MISS_PULSE, MISS_LEFT, STATE
  );
endinterface

// File: rtl/frame_counter.sv
// Saturating frame-tick counter; hit flags the tick that completes limit ticks.
module frame_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         hit
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (tick && (cnt != limit))
      cnt <= cnt + W'(1);
  end

  assign hit = tick && (cnt >= (limit - W'(1)));
endmodule

// File: rtl/match_sequencer.sv
// Game-level FSM: coin start, score clear, serve delay, miss handshake, game over.
module match_sequencer
  import pong_ctrl_pkg::*;
#(
  parameter int SRST_CYCLES  = SRST_CYCLES_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int OVER_FRAMES  = OVER_FRAMES_DEF
) (
  input  logic               CLK_DRV,
  input  logic               RESET,
  match_sequencer_if.slave   bus
);
  localparam int FW = $clog2(max2(SERVE_FRAMES, OVER_FRAMES) + 1);
  localparam int CW = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES + 1) : 1;

  match_state_t  state, state_nxt;
  logic          coin_q, miss_n_q, coin_rise, miss_fall;
  logic [CW-1:0] clr_cnt;
  logic          fc_clr, fc_hit;
  logic [FW-1:0] fc_limit;
  logic          srst_q, attract_n_q, hold_q, pulse_q, left_q;

  assign coin_rise = bus.COIN & ~coin_q;
  assign miss_fall = ~bus.MISS_N & miss_n_q;

  // One counter serves both SERVE_WAIT and OVER; every state entry restarts it.
  assign fc_clr   = (state_nxt != state);
  assign fc_limit = (state == OVER) ? FW'(OVER_FRAMES) : FW'(SERVE_FRAMES);

  frame_counter #(.W(FW)) u_frame (
    .clk   (CLK_DRV),
    .rst   (RESET),
    .clr   (fc_clr),
    .tick  (bus.FRAME_TICK),
    .limit (fc_limit),
    .hit   (fc_hit)
  );

  always_ff @(posedge CLK_DRV) begin
    if (RESET) state <= ATTRACT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ATTRACT:    if (coin_rise) state_nxt = CLEAR;
      CLEAR:      if (clr_cnt == CW'(SRST_CYCLES - 1)) state_nxt = SERVE_WAIT;
      SERVE_WAIT: if (fc_hit) state_nxt = PLAY;
      PLAY:       if (miss_fall) state_nxt = POINT;
      // STOP_G is only trusted on the exit tick, after its register has settled.
      POINT:      if (bus.MISS_N && bus.FRAME_TICK)
                    state_nxt = bus.STOP_G ? OVER : SERVE_WAIT;
      OVER:       if (coin_rise)   state_nxt = CLEAR;
                  else if (fc_hit) state_nxt = ATTRACT;
      default:    state_nxt = ATTRACT;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as STATE.
  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      coin_q      <= 1'b0;
      miss_n_q    <= 1'b1;
      clr_cnt     <= '0;
      srst_q      <= 1'b0;
      attract_n_q <= 1'b0;
      hold_q      <= 1'b0;
      pulse_q     <= 1'b0;
      left_q      <= 1'b0;
    end else begin
      coin_q      <= bus.COIN;
      miss_n_q    <= bus.MISS_N;
      clr_cnt     <= (state == CLEAR && state_nxt == CLEAR) ? clr_cnt + CW'(1) : '0;
      srst_q      <= (state_nxt == CLEAR);
      attract_n_q <= !(state_nxt == ATTRACT || state_nxt == OVER);
      hold_q      <= (state_nxt inside {CLEAR, SERVE_WAIT, POINT, OVER});
      pulse_q     <= (state == PLAY) && miss_fall;
      if ((state == PLAY) && miss_fall) left_q <= bus.L;
    end
  end

  assign bus.SRST       = srst_q;
  assign bus.SRST_N     = ~srst_q;
  assign bus.ATTRACT_N  = attract_n_q;
  assign bus.SERVE_HOLD = hold_q;
  assign bus.MISS_PULSE = pulse_q;
  assign bus.MISS_LEFT  = left_q;
  assign bus.STATE      = state;
endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: vector table for game start, scripted multi-cycle scenarios.
module tb_match_sequencer;
  import pong_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  match_sequencer_if bus();
  match_sequencer dut (.CLK_DRV(clk), .RESET(rst), .bus(bus));

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];

  typedef struct {
    logic         coin;
    logic         miss_n;
    logic         tick;
    match_state_t st;
    logic         srst;
    logic         an;
    logic         hold;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Advance one clock; any MISS_PULSE is matched against the scoreboard queue.
  task automatic step();
    logic e;
    @(posedge clk);
    #1;
    if (bus.MISS_PULSE === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_miss_pulse got=1 want=0");
      end else begin
        e = exp_q.pop_front();
        if (bus.MISS_LEFT !== e) begin
          failures++;
          $display("FAIL miss_left_sb got=%0d want=%0d", bus.MISS_LEFT, e);
        end
      end
    end
  endtask

  task automatic chk_out(input string name, input match_state_t st, input logic srst,
                         input logic an, input logic hold);
    chk({name, "_state"}, 32'(bus.STATE), 32'(st));
    chk({name, "_srst"},  32'(bus.SRST), 32'(srst));
    chk({name, "_srst_n"}, 32'(bus.SRST_N), 32'(!srst));
    chk({name, "_attract_n"}, 32'(bus.ATTRACT_N), 32'(an));
    chk({name, "_hold"},  32'(bus.SERVE_HOLD), 32'(hold));
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.FRAME_TICK = 1'b1; step();
      bus.FRAME_TICK = 1'b0; step();
    end
  endtask

  task automatic clear_rest();
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("clear_hold", CLEAR, 1, 1, 1);
    end
    step(); chk_out("clear_exit", SERVE_WAIT, 0, 1, 1);
  endtask

  task automatic start_game();
    bus.COIN = 1'b1; step(); chk_out("coin_start", CLEAR, 1, 1, 1);
    bus.COIN = 1'b0; bus.STOP_G = 1'b0;
    clear_rest();
  endtask

  task automatic serve_rest(input int done);
    tick_n(SERVE_FRAMES_DEF - 1 - done);
    chk_out("serve_59", SERVE_WAIT, 0, 1, 1);
    bus.FRAME_TICK = 1'b1; step(); bus.FRAME_TICK = 1'b0;
    chk_out("serve_60", PLAY, 0, 1, 0);
  endtask

  task automatic miss(input logic side, input int low_cycles);
    bus.MISS_N = 1'b0; bus.L = side;
    exp_q.push_back(side);
    step(); chk_out("miss_enter", POINT, 0, 1, 1);
    for (int i = 1; i < low_cycles; i++) step();
    bus.FRAME_TICK = 1'b1; step(); bus.FRAME_TICK = 1'b0;
    chk_out("miss_low_tick", POINT, 0, 1, 1);
    bus.MISS_N = 1'b1; step();
    chk_out("miss_release", POINT, 0, 1, 1);
    chk("miss_left_held", 32'(bus.MISS_LEFT), 32'(side));
  endtask

  initial begin
    vecs[0] = '{1, 1, 0, CLEAR,      1, 1, 1};
    vecs[1] = '{1, 1, 0, CLEAR,      1, 1, 1};
    vecs[2] = '{0, 1, 0, CLEAR,      1, 1, 1};
    vecs[3] = '{1, 1, 0, CLEAR,      1, 1, 1};
    vecs[4] = '{0, 1, 0, SERVE_WAIT, 0, 1, 1};
    vecs[5] = '{0, 0, 0, SERVE_WAIT, 0, 1, 1};
    vecs[6] = '{0, 1, 1, SERVE_WAIT, 0, 1, 1};

    bus.FRAME_TICK = 1'b0; bus.COIN = 1'b0; bus.MISS_N = 1'b1;
    bus.L = 1'b0; bus.STOP_G = 1'b0;
    rst = 1'b1; step(); step();
    chk_out("reset", ATTRACT, 0, 0, 0);
    chk("reset_pulse", 32'(bus.MISS_PULSE), 0);
    chk("reset_left", 32'(bus.MISS_LEFT), 0);
    rst = 1'b0;

    // Coin start, CLEAR length, ignored coin/miss edges, first serve tick.
    foreach (vecs[i]) begin
      bus.COIN = vecs[i].coin; bus.MISS_N = vecs[i].miss_n; bus.FRAME_TICK = vecs[i].tick;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].srst, vecs[i].an, vecs[i].hold);
    end
    bus.FRAME_TICK = 1'b0;
    serve_rest(1);

    bus.COIN = 1'b1; step(); chk_out("coin_in_play", PLAY, 0, 1, 0);
    bus.COIN = 1'b0; step();

    miss(1'b1, 40);
    bus.FRAME_TICK = 1'b1; step(); bus.FRAME_TICK = 1'b0;
    chk_out("point_to_serve", SERVE_WAIT, 0, 1, 1);
    serve_rest(0);

    miss(1'b0, 3);
    bus.STOP_G = 1'b1; bus.FRAME_TICK = 1'b1; step(); bus.FRAME_TICK = 1'b0;
    chk_out("point_to_over", OVER, 0, 0, 1);
    chk("over_left", 32'(bus.MISS_LEFT), 0);

    tick_n(99);
    chk_out("over_99", OVER, 0, 0, 1);
    bus.COIN = 1'b1; bus.FRAME_TICK = 1'b1; step();
    bus.COIN = 1'b0; bus.FRAME_TICK = 1'b0; bus.STOP_G = 1'b0;
    chk_out("over_coin", CLEAR, 1, 1, 1);
    clear_rest();
    serve_rest(0);

    miss(1'b1, 2);
    bus.STOP_G = 1'b1; bus.FRAME_TICK = 1'b1; step(); bus.FRAME_TICK = 1'b0;
    chk_out("over_again", OVER, 0, 0, 1);
    tick_n(179);
    chk_out("over_179", OVER, 0, 0, 1);
    bus.FRAME_TICK = 1'b1; step(); bus.FRAME_TICK = 1'b0;
    chk_out("over_timeout", ATTRACT, 0, 0, 0);
    chk("attract_left_kept", 32'(bus.MISS_LEFT), 1);

    start_game();
    serve_rest(0);
    rst = 1'b1; step(); rst = 1'b0;
    chk_out("reset_in_play", ATTRACT, 0, 0, 0);
    chk("reset_in_play_pulse", 32'(bus.MISS_PULSE), 0);
    chk("reset_in_play_left", 32'(bus.MISS_LEFT), 0);
    start_game();
    serve_rest(0);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
